ghost_mode_scheduler: RTL
=========================

// Module: ghost_mode_scheduler
// PURPOSE
//  Global sequencer for all four ghost movers. Generates the shared 60 Hz move tick, the
//  scatter/chase phase schedule, frightened mode after a power pellet, per-ghost release
//  flags and one-cycle direction-reversal requests. Sits between game control and the
//  ghost modules, driving their isChase/isScatter/enable inputs from one timebase.
// PARAMETERS
//  TICK_DIV   416_666  clk cycles per move tick (25 MHz -> 60 Hz)
//  SEC_TICKS  60       move ticks per schedule second
//  SCAT_S     7        scatter length (s), phases 0 and 2
//  SCAT2_S    5        scatter length (s), phases 4 and 6
//  CHASE_S    20       chase length (s), phases 1, 3, 5; phase 7 = chase forever
//  FRIGHT_S   6        frightened duration (s)
//  WARN_S     2        fright_warn asserted during final WARN_S seconds of fright
//  REL0..REL3 5,9,13,17  release time (s after level start) for blinky,pinky,inky,clyde
// PORTS
//  clk           in   1  system clock
//  reset_n       in   1  asynchronous, active-low reset
//  enable        in   1  run gate; low = pause (dying, level clear)
//  level_start   in   1  1-cycle pulse: restart schedule from phase 0
//  power_pellet  in   1  1-cycle pulse: enter/restart frightened
//  move_tick     out  1  1-cycle pulse every TICK_DIV clk while enable
//  isScatter     out  1  scatter mode active
//  isChase       out  1  chase mode active
//  isFright      out  1  frightened mode active
//  fright_warn   out  1  fright ending soon (sprite flash)
//  release       out  4  sticky per-ghost release flags, bit0 = blinky
//  reverse_req   out  4  1-cycle pulse, all bits equal: ghosts must reverse
//  phase_idx     out  3  current schedule phase 0..7
// BEHAVIOUR
//  - Reset: all outputs 0 except isScatter=1; phase_idx=0; all counters 0; state SCATTER.
//  - Divider: counts 0..TICK_DIV-1 only while enable; at TICK_DIV-1 wraps and move_tick=1
//    next cycle. enable low freezes divider, no move_tick. sec pulse internal: every
//    SEC_TICKS move ticks (sub-counter also frozen while paused).
//  - States SCATTER, CHASE, FRIGHT. isScatter/isChase/isFright registered, one-hot exactly.
//  - phase_sec counts seconds in SCATTER/CHASE; at phase length: phase_idx+1, state
//    toggles, phase_sec=0, reverse_req=4'hF for one cycle. Phase 7 CHASE never ends
//    (phase_idx saturates at 7, phase_sec frozen).
//  - power_pellet (accepted even when enable low): state->FRIGHT, saved_mode holds
//    SCATTER/CHASE, fright_sec=0, reverse_req pulses. phase_sec is frozen during FRIGHT.
//    Pellet while already FRIGHT: fright_sec=0, reverse_req pulses, saved_mode unchanged.
//  - FRIGHT exit at fright_sec==FRIGHT_S: return to saved_mode, phase_sec resumes from
//    frozen value, no reverse_req. fright_warn=1 while fright_sec>=FRIGHT_S-WARN_S, 0 outside.
//  - Elapsed-seconds counter (8 bit, saturates 255) counts every sec pulse in any state;
//    release[i] set when elapsed>=REL_i; sticky until level_start or reset.
//  - level_start: same-cycle as power_pellet -> level_start wins (pellet dropped). Clears
//    divider, all counters, release, phase_idx; state SCATTER; no reverse_req.
//  - Phase boundary and pellet same cycle: pellet wins; phase advance is NOT taken and
//    completes once fright ends (phase_sec already at length -> advance on first sec pulse).
//  - reset_n low mid-operation: immediate return to reset values regardless of state.
// TESTING (TICK_DIV=2, SEC_TICKS=2 -> 1 s = 4 clk; lengths as default)
//  - Release, enable=1 -> move_tick every 2 clk; isScatter=1; isChase=1 & reverse_req=F at
//    28 clk; phase_idx=1.
//  - Run 200 s of ticks -> phase sequence 0..7 with lengths 7,20,7,20,5,20,5, then chase
//    held, phase_idx=7, no further reverse_req.
//  - Pellet at phase 1 sec 10 -> isFright=1, reverse pulse; warn at +4 s; back to chase at
//    +6 s; chase change to scatter after 10 more s.
//  - Second pellet at fright sec 5 -> fright restarts, warn drops, total fright 11 s.
//  - enable low 40 clk -> no move_tick, counters unchanged; release[1] appears at 9 s of
//    enabled time, release[3] at 17 s.
//  - level_start+pellet same cycle -> isScatter=1, isFright=0, release=0, phase_idx=0;
//    reset_n pulse mid-fright -> reset values next cycle.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// Global ghost sequencer: move-tick divider, scatter/chase phase schedule,
// frightened mode, per-ghost release flags and reversal requests.
module ghost_mode_scheduler #(
  parameter int unsigned TICK_DIV  = 416_666,
  parameter int unsigned SEC_TICKS = 60,
  parameter int unsigned SCAT_S    = 7,
  parameter int unsigned SCAT2_S   = 5,
  parameter int unsigned CHASE_S   = 20,
  parameter int unsigned FRIGHT_S  = 6,
  parameter int unsigned WARN_S    = 2,
  parameter int unsigned REL0      = 5,
  parameter int unsigned REL1      = 9,
  parameter int unsigned REL2      = 13,
  parameter int unsigned REL3      = 17
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  input  logic       level_start_i,
  input  logic       power_pellet_i,
  output logic       move_tick_o,
  output logic       isScatter_o,
  output logic       isChase_o,
  output logic       isFright_o,
  output logic       fright_warn_o,
  output logic [3:0] release_o,
  output logic [3:0] reverse_req_o,
  output logic [2:0] phase_idx_o
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUB_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SEC_TICKS - 1);
  localparam logic [7:0] SCAT_L   = 8'(SCAT_S);
  localparam logic [7:0] SCAT2_L  = 8'(SCAT2_S);
  localparam logic [7:0] CHASE_L  = 8'(CHASE_S);
  localparam logic [7:0] FRIGHT_L = 8'(FRIGHT_S);
  localparam logic [7:0] WARN_AT  = 8'(FRIGHT_S - WARN_S);
  localparam logic [7:0] REL0_L   = 8'(REL0);
  localparam logic [7:0] REL1_L   = 8'(REL1);
  localparam logic [7:0] REL2_L   = 8'(REL2);
  localparam logic [7:0] REL3_L   = 8'(REL3);

  // One-hot encoding so the mode outputs come straight from state flops.
  typedef enum logic [2:0] {
    SCATTER = 3'b001,
    CHASE   = 3'b010,
    FRIGHT  = 3'b100
  } mode_e;

  mode_e            state_q, state_d, saved_q, saved_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             tick_q, tick_d;
  logic [7:0]       phase_sec_q, phase_sec_d;
  logic [7:0]       fright_sec_q, fright_sec_d;
  logic [7:0]       elapsed_q, elapsed_d;
  logic [2:0]       phase_q, phase_d;
  logic [3:0]       release_q, release_d;
  logic [3:0]       rev_q, rev_d;
  logic [7:0]       phase_len;
  logic             tick_evt, sec_evt;

  assign tick_evt = enable_i && (div_q == DIV_LAST);
  assign sec_evt  = tick_evt && (sub_q == SUB_LAST);

  always_comb begin
    phase_len = CHASE_L;
    unique case (phase_q)
      3'd0, 3'd2: phase_len = SCAT_L;
      3'd4, 3'd6: phase_len = SCAT2_L;
      default:    phase_len = CHASE_L;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= SCATTER;
      saved_q      <= SCATTER;
      div_q        <= '0;
      sub_q        <= '0;
      tick_q       <= 1'b0;
      phase_sec_q  <= '0;
      fright_sec_q <= '0;
      elapsed_q    <= '0;
      phase_q      <= '0;
      release_q    <= '0;
      rev_q        <= '0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      div_q        <= div_d;
      sub_q        <= sub_d;
      tick_q       <= tick_d;
      phase_sec_q  <= phase_sec_d;
      fright_sec_q <= fright_sec_d;
      elapsed_q    <= elapsed_d;
      phase_q      <= phase_d;
      release_q    <= release_d;
      rev_q        <= rev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    div_d        = div_q;
    sub_d        = sub_q;
    tick_d       = tick_evt;
    phase_sec_d  = phase_sec_q;
    fright_sec_d = fright_sec_q;
    elapsed_d    = elapsed_q;
    phase_d      = phase_q;
    rev_d        = '0;

    if (enable_i) begin
      div_d = tick_evt ? '0 : div_q + DIV_W'(1);
      if (tick_evt) sub_d = sec_evt ? '0 : sub_q + SUB_W'(1);
    end
    if (sec_evt && elapsed_q != 8'hFF) elapsed_d = elapsed_q + 8'd1;

    unique case (state_q)
      SCATTER, CHASE: begin
        // A boundary second coinciding with a pellet is still counted, so
        // phase_sec reaches the length and the advance fires on the first
        // second after fright ends (hence >= rather than ==).
        if (sec_evt && phase_q != 3'd7) begin
          if ((phase_sec_q + 8'd1) >= phase_len && !power_pellet_i) begin
            phase_d     = phase_q + 3'd1;
            phase_sec_d = '0;
            state_d     = (state_q == SCATTER) ? CHASE : SCATTER;
            rev_d       = 4'hF;
          end else begin
            phase_sec_d = phase_sec_q + 8'd1;
          end
        end
        if (power_pellet_i) begin
          state_d      = FRIGHT;
          saved_d      = state_q;
          fright_sec_d = '0;
          rev_d        = 4'hF;
        end
      end
      FRIGHT: begin
        if (power_pellet_i) begin
          fright_sec_d = '0;
          rev_d        = 4'hF;
        end else if (sec_evt) begin
          if ((fright_sec_q + 8'd1) >= FRIGHT_L) begin
            state_d      = saved_q;
            fright_sec_d = '0;
          end else begin
            fright_sec_d = fright_sec_q + 8'd1;
          end
        end
      end
      default: state_d = SCATTER;
    endcase

    release_d = release_q | {elapsed_d >= REL3_L, elapsed_d >= REL2_L,
                             elapsed_d >= REL1_L, elapsed_d >= REL0_L};

    if (level_start_i) begin
      state_d      = SCATTER;
      saved_d      = SCATTER;
      div_d        = '0;
      sub_d        = '0;
      tick_d       = 1'b0;
      phase_sec_d  = '0;
      fright_sec_d = '0;
      elapsed_d    = '0;
      phase_d      = '0;
      release_d    = '0;
      rev_d        = '0;
    end
  end

  assign move_tick_o   = tick_q;
  assign isScatter_o   = (state_q == SCATTER);
  assign isChase_o     = (state_q == CHASE);
  assign isFright_o    = (state_q == FRIGHT);
  assign fright_warn_o = (state_q == FRIGHT) && (fright_sec_q >= WARN_AT);
  assign release_o     = release_q;
  assign reverse_req_o = rev_q;
  assign phase_idx_o   = phase_q;

endmodule
